shift_add_mult32: RTL

- Sequential unsigned 32x32 -> 64-bit shift-and-add multiplier.
- Sits directly upstream of the team's 32-bit ripple-carry adder and drives it: each iteration, it feeds the adder the upper partial-product half and the multiplicand, then consumes the sum and carry-out.
- Provides the multiply path for the arithmetic unit without a combinational array multiplier.
- Start/done handshake; one iteration per clock.

---
 rtl/shift_add_mult32_pkg.sv | 21 ++
 rtl/RCA32.sv | 31 +++
 rtl/shift_add_mult32.sv | 110 +++++++++++
 3 files changed

// File: rtl/shift_add_mult32_pkg.sv
// ============================================================================
// Module  : shift_add_mult32_pkg
// Brief   : Shared constants and FSM state encoding for shift_add_mult32.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_add_mult32_pkg;

   localparam int unsigned c_width    = 32;
   localparam int unsigned c_num_iter = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage : shift_add_mult32_pkg

`default_nettype wire

// File: rtl/RCA32.sv
// ============================================================================
// Module  : RCA32
// Brief   : 32-bit ripple-carry adder, S = A1 + A2 + in, carry-out on C.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module RCA32 (
   input  logic [31:0] A1,
   input  logic [31:0] A2,
   input  logic        in,
   output logic [31:0] S,
   output logic        C
);

   logic carry;

   // Carry ripples through a loop variable so no combinational array feeds itself.
   always_comb begin
      S     = '0;
      carry = in;
      for (int i = 0; i < 32; i++) begin
         S[i]  = A1[i] ^ A2[i] ^ carry;
         carry = (A1[i] & A2[i]) | (carry & (A1[i] ^ A2[i]));
      end
      C = carry;
   end

endmodule : RCA32

`default_nettype wire

// File: rtl/shift_add_mult32.sv
// ============================================================================
// Module  : shift_add_mult32
// Brief   : Sequential unsigned 32x32->64 shift-and-add multiplier, start/done.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_mult32
   import shift_add_mult32_pkg::*;
#(
   parameter int WIDTH = c_width,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(c_num_iter - 1);

   state_t               state_q;
   logic [WIDTH-1:0]     m_q;
   logic [2*WIDTH-1:0]   p_q;
   logic [2*WIDTH-1:0]   p_d;
   logic [2*WIDTH-1:0]   product_q;
   logic [CNT_W-1:0]     count_q;
   logic                 busy_q;
   logic                 done_q;

   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     sum;
   logic                 carry;

   assign addend = p_q[0] ? m_q : '0;

   RCA32 u_rca (
      .A1 (p_q[2*WIDTH-1:WIDTH]),
      .A2 (addend),
      .in (1'b0),
      .S  (sum),
      .C  (carry)
   );

   // 65-bit {carry, upper, lower} shifted right by one; carry lands in the MSB.
   assign p_d = {carry, sum, p_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         m_q       <= '0;
         p_q       <= '0;
         product_q <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  m_q     <= a;
                  p_q     <= {{WIDTH{1'b0}}, b};
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               p_q     <= p_d;
               count_q <= count_q + CNT_W'(1);
               if (count_q == c_last_cnt) begin
                  product_q <= p_d;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  m_q     <= a;
                  p_q     <= {{WIDTH{1'b0}}, b};
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule : shift_add_mult32

`default_nettype wire
